// File: rtl/freq_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package freq_div_pkg;

  localparam int RATIO_W = 10;

  typedef enum logic [1:0] {IDLE, PEND, ACKD} upd_state_t;

  // Length of the high phase: ceil(n/2), one bit wider so n=1023 cannot overflow.
  function automatic logic [RATIO_W:0] half_up(input logic [RATIO_W-1:0] n);
    return ({1'b0, n} + 11'd1) >> 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit multi-flop synchroniser for quasi-static or asynchronous control inputs.
module sync_2ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/freq_div_by_n_10b.sv
// Programmable integer clock divider with a req/ack ratio update that is
// applied only on an output-period boundary, plus a clkin bypass.
module freq_div_by_n_10b
  import freq_div_pkg::*;
#(
  parameter logic [RATIO_W-1:0] DEFAULT_RATIO = 10'd2,
  parameter int                 SYNC_STAGES   = 2
) (
  input  logic               clkin,
  input  logic               rstb,
  input  logic               bypass,
  input  logic [RATIO_W-1:0] ratio,
  input  logic               ratio_upd_req,
  output logic               ratio_upd_ack,
  output logic               clkout
);

  logic req_s;
  logic bypass_s;

  logic [RATIO_W-1:0] active_ratio_q, active_ratio_d;
  logic [RATIO_W-1:0] pend_ratio_q,   pend_ratio_d;
  logic [RATIO_W-1:0] cnt_q,          cnt_d;
  logic               div_clk_q,      div_clk_d;
  logic               ack_q,          ack_d;
  upd_state_t         state_q,        state_d;

  logic               div_by_one;
  logic               at_boundary;
  logic [RATIO_W:0]   high_len;

  sync_2ff #(.DEPTH(SYNC_STAGES)) u_req_sync (
    .clk (clkin),
    .rst (rstb),
    .d   (ratio_upd_req),
    .q   (req_s)
  );

  sync_2ff #(.DEPTH(SYNC_STAGES)) u_bypass_sync (
    .clk (clkin),
    .rst (rstb),
    .d   (bypass),
    .q   (bypass_s)
  );

  always_comb begin
    div_by_one  = (active_ratio_q <= 10'd1);
    high_len    = half_up(active_ratio_q);
    at_boundary = div_by_one || (cnt_q == (active_ratio_q - 10'd1));
  end

  // div_clk is held high in divide-by-1 so leaving that mode never produces a runt.
  always_comb begin
    cnt_d     = at_boundary ? '0 : (cnt_q + 10'd1);
    div_clk_d = div_by_one ? 1'b1 : ({1'b0, cnt_q} < high_len);
  end

  always_comb begin
    state_d        = state_q;
    pend_ratio_d   = pend_ratio_q;
    active_ratio_d = active_ratio_q;
    ack_d          = ack_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          pend_ratio_d = ratio;
          state_d      = PEND;
        end
      end
      PEND: begin
        if (at_boundary) begin
          active_ratio_d = pend_ratio_q;
          ack_d          = 1'b1;
          state_d        = ACKD;
        end
      end
      ACKD: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rstb) begin
      active_ratio_q <= DEFAULT_RATIO;
      pend_ratio_q   <= DEFAULT_RATIO;
      cnt_q          <= '0;
      div_clk_q      <= 1'b0;
      ack_q          <= 1'b0;
      state_q        <= IDLE;
    end else begin
      active_ratio_q <= active_ratio_d;
      pend_ratio_q   <= pend_ratio_d;
      cnt_q          <= cnt_d;
      div_clk_q      <= div_clk_d;
      ack_q          <= ack_d;
      state_q        <= state_d;
    end
  end

  assign ratio_upd_ack = ack_q;
  assign clkout        = (bypass_s || div_by_one) ? clkin : div_clk_q;

endmodule

// File: tb/tb_freq_div_by_n_10b.sv
// Self-checking bench for freq_div_by_n_10b: measures clkout high/low run
// lengths and handshake latencies against the divider's arithmetic rules.
module tb_freq_div_by_n_10b;

  logic       clkin = 1'b0;
  logic       rstb;
  logic       bypass;
  logic [9:0] ratio;
  logic       req;
  logic       ack;
  logic       clkout;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int model_ratio = 2;

  logic mon_last  = 1'b0;
  int   mon_run   = 0;
  int   last_rise = 0;
  int   run_len_q[$];
  bit   run_lvl_q[$];

  freq_div_by_n_10b #(
    .DEFAULT_RATIO (10'd2),
    .SYNC_STAGES   (2)
  ) dut (
    .clkin         (clkin),
    .rstb          (rstb),
    .bypass        (bypass),
    .ratio         (ratio),
    .ratio_upd_req (req),
    .ratio_upd_ack (ack),
    .clkout        (clkout)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  // Records every completed clkout run (level and length in clkin cycles).
  always begin
    @(posedge clkin);
    #1;
    if (clkout === mon_last) begin
      mon_run = mon_run + 1;
    end else begin
      run_len_q.push_back(mon_run);
      run_lvl_q.push_back(mon_last);
      if (clkout === 1'b1) last_rise = cyc;
      mon_last = clkout;
      mon_run  = 1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int effN(input int n);
    return (n <= 1) ? 1 : n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    if (obs !== exp) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sampleNext(output logic s);
    @(posedge clkin);
    #1;
    s = clkout;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  // Measures two full output periods and compares them to ceil(N/2) / floor(N/2).
  task automatic checkPeriods(input int n);
    logic s;
    int   k, hi, lo, errs, bound;
    if (n <= 1) begin
      errs = 0;
      repeat (6) begin
        @(posedge clkin); #1;
        if (clkout !== clkin) errs++;
        @(negedge clkin); #1;
        if (clkout !== clkin) errs++;
      end
      @(posedge clkin); #1;
      checkOutput($sformatf("div1_follows_clkin_n%0d", n), errs, 0);
    end else begin
      bound = 6 * n + 10;
      k = 0;
      s = 1'b1;
      while (s !== 1'b0 && k < bound) begin sampleNext(s); k++; end
      while (s !== 1'b1 && k < bound) begin sampleNext(s); k++; end
      for (int p = 0; p < 2; p++) begin
        hi = 0;
        while (s === 1'b1 && k < bound) begin hi++; sampleNext(s); k++; end
        lo = 0;
        while (s === 1'b0 && k < bound) begin lo++; sampleNext(s); k++; end
        checkOutput($sformatf("high_len_n%0d", n), hi, (n + 1) / 2);
        checkOutput($sformatf("low_len_n%0d", n), lo, n / 2);
      end
    end
  endtask

  // Full ratio-update handshake; early=1 drops req while the update is still pending.
  task automatic applyStimulus(input int new_r, input bit early);
    int   old_r, lat, bound, viol;
    logic a;
    old_r = model_ratio;
    run_len_q.delete();
    run_lvl_q.delete();
    ratio = 10'(new_r);
    req   = 1'b1;
    bound = 2 + effN(old_r) + 1;
    lat   = 0;
    a     = 1'b0;
    while (a !== 1'b1 && lat < bound + 20) begin
      @(posedge clkin); #1;
      lat++;
      a = ack;
      if (early && lat == 3) req = 1'b0;
    end
    checkOutput($sformatf("ack_rise_within_%0d", bound), (a === 1'b1 && lat <= bound), 1);
    req = 1'b0;
    lat = 0;
    while (a !== 1'b0 && lat < 10) begin
      @(posedge clkin); #1;
      lat++;
      a = ack;
    end
    checkOutput("ack_fall_within_3", (a === 1'b0 && lat <= 3), 1);
    model_ratio = new_r;
    checkPeriods(new_r);
    if (old_r >= 2 && new_r >= 2) begin
      viol = 0;
      for (int i = 1; i < run_len_q.size(); i++) begin
        if (run_lvl_q[i]) begin
          if (run_len_q[i] != (old_r + 1) / 2 && run_len_q[i] != (new_r + 1) / 2) viol++;
        end else begin
          if (run_len_q[i] != old_r / 2 && run_len_q[i] != new_r / 2) viol++;
        end
      end
      checkOutput($sformatf("no_runt_%0d_to_%0d", old_r, new_r), viol, 0);
    end
  endtask

  initial begin
    int   errs, t0, t1, k, r;
    logic s;
    bit   e;

    rstb   = 1'b1;
    bypass = 1'b0;
    req    = 1'b0;
    ratio  = 10'd2;
    waitCycles(3);
    checkOutput("reset_clkout", clkout, 0);
    checkOutput("reset_ack", ack, 0);
    rstb = 1'b0;
    waitCycles(1);
    checkOutput("first_high_after_reset", clkout, 1);
    model_ratio = 2;

    errs = 0;
    repeat (40) begin
      waitCycles(1);
      if (ack !== 1'b0) errs++;
    end
    checkOutput("ack_idle_40", errs, 0);
    checkPeriods(2);

    applyStimulus(10, 1'b0);
    applyStimulus(15, 1'b0);

    $display("[TB] bypass phase");
    t0 = last_rise;
    bypass = 1'b1;
    waitCycles(3);
    errs = 0;
    repeat (195) begin
      @(negedge clkin); #1;
      if (clkout !== clkin) errs++;
      @(posedge clkin); #1;
      if (clkout !== clkin) errs++;
    end
    checkOutput("bypass_follows_clkin", errs, 0);
    bypass = 1'b0;
    k = 0;
    s = 1'b1;
    while (s !== 1'b0 && k < 100) begin sampleNext(s); k++; end
    while (s !== 1'b1 && k < 100) begin sampleNext(s); k++; end
    t1 = cyc;
    checkOutput("bypass_exit_rise_seen", (k < 100), 1);
    checkOutput("bypass_exit_phase", (t1 - t0) % 15, 0);
    checkPeriods(15);

    $display("[TB] randomized ratio updates");
    for (int i = 0; i < 5; i++) begin
      r = int'($urandom_range(60, 2));
      e = bit'($urandom_range(1, 0));
      applyStimulus(r, e);
    end

    applyStimulus(1, 1'b0);
    applyStimulus(0, 1'b0);
    applyStimulus(40, 1'b0);

    $display("[TB] reset during pending update");
    k = 0;
    s = 1'b1;
    while (s !== 1'b0 && k < 100) begin sampleNext(s); k++; end
    while (s !== 1'b1 && k < 100) begin sampleNext(s); k++; end
    ratio = 10'd33;
    req   = 1'b1;
    waitCycles(5);
    checkOutput("ack_low_while_pend", ack, 0);
    rstb = 1'b1;
    req  = 1'b0;
    waitCycles(2);
    checkOutput("reset_mid_ack", ack, 0);
    checkOutput("reset_mid_clkout", clkout, 0);
    rstb = 1'b0;
    model_ratio = 2;
    waitCycles(1);
    checkOutput("first_high_after_mid_reset", clkout, 1);
    errs = 0;
    repeat (80) begin
      waitCycles(1);
      if (ack !== 1'b0) errs++;
    end
    checkOutput("no_ack_after_mid_reset", errs, 0);
    checkPeriods(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
